// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control bundle between the multicycle sequencer and the datapath/memory
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       doshift;
  logic [3:0] state;
  logic       retire;
  logic       illegal;
  logic       mem_timeout;
  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
           regwrite, alusrca, alusrcb, aluop, pcsource, doshift, state, retire, illegal, mem_timeout
  );
  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
           regwrite, alusrca, alusrcb, aluop, pcsource, doshift, state, retire, illegal, mem_timeout
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: registered fetch/decode/execute/memory/writeback sequencer for the MIPS core
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RTYPE_WB,
    BRANCH, ADDI_EX, ADDI_WB, JUMP, TRAP
  } state_t;
  localparam logic [7:0] TO    = 8'(MEM_WAIT_TIMEOUT);
  localparam logic       TO_EN = MEM_WAIT_TIMEOUT != 0;
  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       waiting;
  always_comb begin
    state_d          = state_q;
    bus.pcwrite      = 1'b0;
    bus.pcwritecond  = 1'b0;
    bus.iord         = 1'b0;
    bus.memread      = 1'b0;
    bus.memwrite     = 1'b0;
    bus.irwrite      = 1'b0;
    bus.memtoreg     = 1'b0;
    bus.regdst       = 1'b0;
    bus.regwrite     = 1'b0;
    bus.alusrca      = 1'b0;
    bus.alusrcb      = 2'b00;
    bus.aluop        = 2'b00;
    bus.pcsource     = 2'b00;
    bus.doshift      = 1'b0;
    bus.retire       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
        state_d     = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        state_d = (bus.opcode == 6'h23 || bus.opcode == 6'h2B) ? MEMADR :
                  bus.opcode == 6'h00 ? EXEC :
                  bus.opcode == 6'h04 ? BRANCH :
                  bus.opcode == 6'h08 ? ADDI_EX :
                  bus.opcode == 6'h02 ? JUMP : TRAP;
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = bus.opcode == 6'h23 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        state_d     = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        bus.retire   = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        bus.retire   = bus.mem_ready;
        state_d      = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        bus.doshift = 1'b1;
        state_d     = RTYPE_WB;
      end
      RTYPE_WB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        bus.retire   = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.aluop       = 2'b01;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b01;
        bus.retire      = 1'b1;
        state_d         = FETCH;
      end
      ADDI_EX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = ADDI_WB;
      end
      ADDI_WB: begin
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
        state_d      = FETCH;
      end
      JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = 2'b10;
        bus.retire   = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = TRAP;
    endcase
    if (rst) begin
      bus.pcwrite     = 1'b0;
      bus.pcwritecond = 1'b0;
      bus.irwrite     = 1'b0;
      bus.memwrite    = 1'b0;
      bus.regwrite    = 1'b0;
      bus.retire      = 1'b0;
    end
  end
  // Counter only runs while a memory access is stalled and restarts with every state change.
  always_comb begin
    waiting       = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !bus.mem_ready;
    wait_d        = state_d != state_q ? 8'd0 :
                    (waiting && wait_q != 8'hFF) ? wait_q + 8'd1 : wait_q;
    mem_timeout_d = mem_timeout_q | (TO_EN && waiting && wait_d == TO);
    illegal_d     = illegal_q | (state_d == TRAP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      wait_q        <= 8'd0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      illegal_q     <= illegal_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.mem_timeout = mem_timeout_q;
endmodule
